// File: rtl/intr_pkg.sv
// intr_pkg: constants and types shared by the interrupt controller and the
// jump control block.
//   OP_*          control-transfer opcodes (6-bit)
//   intr_state_t  interrupt controller FSM state
//   is_ctl_op()   high for any opcode that redirects the PC
package intr_pkg;

    localparam logic [5:0] OP_JV  = 6'b011100;
    localparam logic [5:0] OP_JNV = 6'b011101;
    localparam logic [5:0] OP_JZ  = 6'b011110;
    localparam logic [5:0] OP_JNZ = 6'b011111;
    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_RET = 6'b010000;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        HOLD1,
        HOLD2,
        SERVICE,
        RETN
    } intr_state_t;

    function automatic logic is_ctl_op(input logic [5:0] op);
        return op inside {OP_JV, OP_JNV, OP_JZ, OP_JNZ, OP_JMP, OP_RET};
    endfunction

endpackage

// File: rtl/intr_controller_if.sv
// intr_controller_if: request/response bundle between the interrupt sources,
// the decode stage and the interrupt controller.
//   irq_in, op, mask_we, mask_wdata   -> controller
//   interrupt, irq_cause, in_service, pending  <- controller
// master = environment / decode side, slave = controller.
interface intr_controller_if #(
    parameter int N_IRQ = 4
);
    logic [N_IRQ-1:0] irq_in;
    logic [5:0]       op;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             interrupt;
    logic [N_IRQ-1:0] irq_cause;
    logic             in_service;
    logic [N_IRQ-1:0] pending;

    modport master (
        output irq_in, op, mask_we, mask_wdata,
        input  interrupt, irq_cause, in_service, pending
    );

    modport slave (
        input  irq_in, op, mask_we, mask_wdata,
        output interrupt, irq_cause, in_service, pending
    );
endinterface

// File: rtl/irq_pending_reg.sv
// irq_pending_reg: rising-edge detect on the interrupt lines and the pending
// latch. A new edge and a clear on the same bit in the same cycle leave the
// bit set, so a request arriving as the previous one is taken is not lost.
//   i_irq      external levels (synchronous)
//   i_clr      one-hot clear of the request being taken
//   o_pending  latched requests
module irq_pending_reg #(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic [N_IRQ-1:0] i_clr,
    output logic [N_IRQ-1:0] o_pending
);
    logic [N_IRQ-1:0] r_irq_prev;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] w_edge;

    // r_irq_prev resets to 0, so a line already high at release is an edge
    assign w_edge = i_irq & ~r_irq_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= i_irq;
            r_pending  <= (r_pending & ~i_clr) | w_edge;
        end
    end

    assign o_pending = r_pending;
endmodule

// File: rtl/intr_controller.sv
// intr_controller: masks and prioritises latched interrupt requests and
// issues one single-cycle interrupt pulse per accepted request. A pulse is
// held off while a control-transfer opcode is in decode and while a previous
// interrupt is in service, protecting jump control's single-level save regs.
//   clk, reset        clock, async active-low reset
//   bus (slave)       irq_in/op/mask_we/mask_wdata in,
//                     interrupt/irq_cause/in_service/pending out
module intr_controller
    import intr_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    intr_controller_if.slave  bus
);
    intr_state_t      r_state;
    intr_state_t      w_state_nxt;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_irq_cause;
    logic             r_interrupt;
    logic             r_in_service;

    logic [N_IRQ-1:0] w_pending;
    logic [N_IRQ-1:0] w_eligible;
    logic [N_IRQ-1:0] w_winner;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_cause_nxt;
    logic             w_ctl_op;
    logic             w_take;
    logic             w_interrupt_nxt;
    logic             w_in_service_nxt;

    irq_pending_reg #(.N_IRQ(N_IRQ)) u_pending (
        .clk       (clk),
        .reset     (reset),
        .i_irq     (bus.irq_in),
        .i_clr     (w_clr),
        .o_pending (w_pending)
    );

    // r_mask is a register, so a write this cycle only affects next decision
    assign w_eligible = w_pending & r_mask;
    // isolate lowest set bit: lowest index wins
    assign w_winner   = w_eligible & (~w_eligible + N_IRQ'(1));
    assign w_ctl_op   = is_ctl_op(bus.op);
    assign w_take     = (r_state == IDLE) && (|w_eligible) && !w_ctl_op;
    assign w_clr      = w_take ? w_winner : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_irq_cause  <= '0;
            r_interrupt  <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_irq_cause  <= w_cause_nxt;
            r_interrupt  <= w_interrupt_nxt;
            r_in_service <= w_in_service_nxt;
            if (bus.mask_we)
                r_mask <= bus.mask_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_take) w_state_nxt = FIRE;
            FIRE:    w_state_nxt = HOLD1;
            // RET here is jump control's own pipeline, not the handler return
            HOLD1:   w_state_nxt = HOLD2;
            HOLD2:   w_state_nxt = SERVICE;
            SERVICE: if (bus.op == OP_RET) w_state_nxt = RETN;
            RETN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // outputs are computed from the next state and registered, so they are
    // clean flop outputs aligned with the state they describe
    always_comb begin
        w_interrupt_nxt  = (w_state_nxt == FIRE);
        w_in_service_nxt = (w_state_nxt != IDLE);
        w_cause_nxt      = r_irq_cause;
        if (w_take)
            w_cause_nxt = w_winner;
        else if (r_state == RETN)
            w_cause_nxt = '0;
    end

    assign bus.interrupt  = r_interrupt;
    assign bus.in_service = r_in_service;
    assign bus.irq_cause  = r_irq_cause;
    assign bus.pending    = w_pending;
endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller. Each vector row gives the inputs
// held across one rising edge and the outputs expected just after it.
module tb_intr_controller;
    import intr_pkg::*;

    localparam int N = 4;

    logic clk;
    logic reset;

    intr_controller_if #(.N_IRQ(N)) bus ();

    intr_controller #(.N_IRQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] irq;
        logic [5:0]   op;
        logic         mwe;
        logic [N-1:0] mw;
        logic         e_int;
        logic [N-1:0] e_cause;
        logic         e_svc;
        logic [N-1:0] e_pend;
    } vec_t;

    typedef struct packed {
        logic         e_int;
        logic [N-1:0] e_cause;
        logic         e_svc;
        logic [N-1:0] e_pend;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   row_no   = 0;
    logic prev_int = 1'b0;

    function automatic vec_t v(logic [N-1:0] irq, logic [5:0] op, logic mwe,
                               logic [N-1:0] mw, logic ei, logic [N-1:0] ec,
                               logic es, logic [N-1:0] ep);
        vec_t r;
        r.irq = irq; r.op = op; r.mwe = mwe; r.mw = mw;
        r.e_int = ei; r.e_cause = ec; r.e_svc = es; r.e_pend = ep;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // rows after FIRE: HOLD1, HOLD2, SERVICE, RET -> RETN, back to IDLE
    task automatic add_service(input logic [N-1:0] cause, input logic [N-1:0] pend);
        vq.push_back(v('0, 6'b0,   0, '0, 0, cause, 1, pend));
        vq.push_back(v('0, 6'b0,   0, '0, 0, cause, 1, pend));
        vq.push_back(v('0, 6'b0,   0, '0, 0, cause, 1, pend));
        vq.push_back(v('0, OP_RET, 0, '0, 0, cause, 1, pend));
        vq.push_back(v('0, 6'b0,   0, '0, 0, '0,    0, pend));
    endtask

    task automatic run_vectors();
        exp_t e;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus.irq_in     = vq[i].irq;
            bus.op         = vq[i].op;
            bus.mask_we    = vq[i].mwe;
            bus.mask_wdata = vq[i].mw;
            sb.push_back({vq[i].e_int, vq[i].e_cause, vq[i].e_svc, vq[i].e_pend});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("interrupt",  row_no, {7'b0, bus.interrupt},  {7'b0, e.e_int});
            chk("irq_cause",  row_no, {4'b0, bus.irq_cause},  {4'b0, e.e_cause});
            chk("in_service", row_no, {7'b0, bus.in_service}, {7'b0, e.e_svc});
            chk("pending",    row_no, {4'b0, bus.pending},    {4'b0, e.e_pend});
            row_no++;
        end
        vq.delete();
        @(negedge clk);
        bus.irq_in = '0; bus.op = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_int"},  -1, {7'b0, bus.interrupt},  8'h0);
        chk({name, "_cause"},-1, {4'b0, bus.irq_cause},  8'h0);
        chk({name, "_svc"},  -1, {7'b0, bus.in_service}, 8'h0);
        chk({name, "_pend"}, -1, {4'b0, bus.pending},    8'h0);
    endtask

    // interrupt must never stay high two cycles running
    always @(negedge clk) begin
        if (reset && bus.interrupt && prev_int) begin
            failures++;
            $display("FAIL interrupt_width: got 2 consecutive cycles expected 1");
        end
        prev_int = bus.interrupt;
    end

    initial begin
        reset = 1'b0;
        bus.irq_in = '0; bus.op = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        // basic latency, RET ignored in HOLD1/HOLD2, RET -> RETN -> IDLE
        vq.push_back(v(4'h0, 6'b0,   1, 4'hF, 0, 4'h0, 0, 4'h0));
        vq.push_back(v(4'h4, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h4));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h4, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h4, 1, 4'h0));
        vq.push_back(v(4'h0, OP_RET, 0, 4'h0, 0, 4'h4, 1, 4'h0));
        vq.push_back(v(4'h0, OP_RET, 0, 4'h0, 0, 4'h4, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h4, 1, 4'h0));
        vq.push_back(v(4'h0, OP_RET, 0, 4'h0, 0, 4'h4, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h0));
        // priority: bits 3 and 1 together, 1 first, 3 after return
        vq.push_back(v(4'hA, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'hA));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h2, 1, 4'h8));
        add_service(4'h2, 4'h8);
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h8, 1, 4'h0));
        add_service(4'h8, 4'h0);
        // deferred by JMP for three cycles, fires the cycle after op clears
        vq.push_back(v(4'h1, OP_JMP, 0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, OP_JMP, 0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, OP_JMP, 0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h1, 1, 4'h0));
        add_service(4'h1, 4'h0);
        // masked source stays pending; decision in write cycle uses old mask
        vq.push_back(v(4'h0, 6'b0,   1, 4'h0, 0, 4'h0, 0, 4'h0));
        vq.push_back(v(4'h1, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   1, 4'h1, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h1, 1, 4'h0));
        add_service(4'h1, 4'h0);
        // new edges during service wait for return; repeated edge not counted
        vq.push_back(v(4'h0, 6'b0,   1, 4'hF, 0, 4'h0, 0, 4'h0));
        vq.push_back(v(4'h1, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h1, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h1, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h1, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h1, 1, 4'h0));
        vq.push_back(v(4'h1, 6'b0,   0, 4'h0, 0, 4'h1, 1, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h1, 1, 4'h1));
        vq.push_back(v(4'h1, 6'b0,   0, 4'h0, 0, 4'h1, 1, 4'h1));
        vq.push_back(v(4'h0, OP_RET, 0, 4'h0, 0, 4'h1, 1, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h1, 1, 4'h0));
        add_service(4'h1, 4'h0);
        // edge on the winner in the cycle it is taken: pending stays set
        vq.push_back(v(4'h1, OP_JMP, 0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h0, OP_JMP, 0, 4'h0, 0, 4'h0, 0, 4'h1));
        vq.push_back(v(4'h1, 6'b0,   0, 4'h0, 1, 4'h1, 1, 4'h1));
        add_service(4'h1, 4'h1);
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h1, 1, 4'h0));
        add_service(4'h1, 4'h0);
        // reach SERVICE with a pending request, for the reset test
        vq.push_back(v(4'h2, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h2));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 1, 4'h2, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h2, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h2, 1, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h2, 1, 4'h0));
        vq.push_back(v(4'h8, 6'b0,   0, 4'h0, 0, 4'h2, 1, 4'h8));
        run_vectors();

        // async reset mid-cycle in SERVICE: everything clears at once
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;

        // no pulse after release without a new edge, even with mask enabled
        vq.push_back(v(4'h0, 6'b0,   1, 4'hF, 0, 4'h0, 0, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h0));
        vq.push_back(v(4'h0, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h0));
        run_vectors();

        // a line high across reset release counts as an edge on first clock
        bus.irq_in = 4'h4;
        reset = 1'b0;
        #1;
        chk_all_zero("reset_hold");
        @(negedge clk);
        reset = 1'b1;
        vq.push_back(v(4'h4, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h4));
        vq.push_back(v(4'h4, 6'b0,   0, 4'h0, 0, 4'h0, 0, 4'h4));
        run_vectors();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
